// File: rtl/addsub.sv
//------------------------------------------------------------------------------
// addsub : registered two's-complement adder/subtractor with Cout/Ov flags.
// Optional macro ADDSUB_SAT_EN saturates S on signed overflow.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module addsub #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] BC,
   input  logic             AS,
   output logic             Cout,
   output logic             Ov,
   output logic [WIDTH-1:0] S,
   output logic             out_valid
);

   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum_full;
   logic [WIDTH-1:0] s_raw;
   logic             carry;
   logic             ovf;
   logic [WIDTH-1:0] s_next;

   // Subtraction is A + ~BC + 1: invert the operand and feed AS as carry-in.
   always_comb begin
      b_eff    = AS ? ~BC : BC;
      sum_full = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, AS};
      s_raw    = sum_full[WIDTH-1:0];
      carry    = sum_full[WIDTH];
      ovf      = (A[WIDTH-1] == b_eff[WIDTH-1]) && (s_raw[WIDTH-1] != A[WIDTH-1]);
   end

`ifdef ADDSUB_SAT_EN
   // Overflow always moves away from A's sign, so A's sign picks the limit.
   always_comb begin
      s_next = s_raw;
      if (ovf) begin
         s_next = A[WIDTH-1] ? SAT_MIN : SAT_MAX;
      end
   end
`else
   always_comb begin
      s_next = s_raw;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S         <= '0;
         Cout      <= 1'b0;
         Ov        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            S    <= s_next;
            Cout <= carry;
            Ov   <= ovf;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_addsub.sv
//------------------------------------------------------------------------------
// tb_addsub : self-checking bench for addsub against an integer-arithmetic model.
//------------------------------------------------------------------------------
`default_nettype none

module tb_addsub;

   localparam int W = 5;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] A;
   logic [W-1:0] BC;
   logic         AS;
   logic         Cout;
   logic         Ov;
   logic [W-1:0] S;
   logic         out_valid;

   int compared;
   int mismatched;

   addsub #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .A        (A),
      .BC       (BC),
      .AS       (AS),
      .Cout     (Cout),
      .Ov       (Ov),
      .S        (S),
      .out_valid(out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: exact integer arithmetic, then range test for signed overflow.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic as, output logic [W-1:0] s,
                                 output logic c, output logic o);
      int ua, ub, sa, sb, sres, smax, smin;
      ua   = int'(a);
      ub   = int'(b);
      sa   = a[W-1] ? ua - (1 << W) : ua;
      sb   = b[W-1] ? ub - (1 << W) : ub;
      smax = (1 << (W-1)) - 1;
      smin = -(1 << (W-1));
      if (!as) begin
         c    = (ua + ub) >= (1 << W);
         sres = sa + sb;
      end else begin
         c    = (ua >= ub);
         sres = sa - sb;
      end
      o = (sres > smax) || (sres < smin);
      s = sres[W-1:0];
`ifdef ADDSUB_SAT_EN
      if (sres > smax) s = smax[W-1:0];
      if (sres < smin) s = smin[W-1:0];
`endif
   endfunction

   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic as);
      @(negedge clk);
      in_valid = v;
      A        = a;
      BC       = b;
      AS       = as;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in_valid = 1'b0; A = '0; BC = '0; AS = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if ({out_valid, Cout, Ov, S} !== {1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
         mismatched++;
         $display("FAIL reset: got ov=%b c=%b o=%b s=%b, want all 0",
                  out_valid, Cout, Ov, S);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      compared++;
      if (out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_release_idle: got out_valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_directed;
      logic [W-1:0] ta [10] = '{5'b00110, 5'b00010, 5'b11101, 5'b11011,
                                5'b00110, 5'b00010, 5'b11101, 5'b11011,
                                5'b00000, 5'b10000};
      logic [W-1:0] tb [10] = '{5'b00001, 5'b01111, 5'b00100, 5'b10100,
                                5'b00001, 5'b01111, 5'b00100, 5'b10100,
                                5'b00000, 5'b00001};
      logic         tas[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
`ifdef ADDSUB_SAT_EN
      logic [W-1:0] es [10] = '{5'b00111, 5'b01111, 5'b00001, 5'b10000,
                                5'b00101, 5'b10011, 5'b11001, 5'b00111,
                                5'b00000, 5'b10000};
`else
      logic [W-1:0] es [10] = '{5'b00111, 5'b10001, 5'b00001, 5'b01111,
                                5'b00101, 5'b10011, 5'b11001, 5'b00111,
                                5'b00000, 5'b01111};
`endif
      logic         ec [10] = '{0, 0, 1, 1, 1, 0, 1, 1, 1, 1};
      logic         eo [10] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 1};
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, ta[i], tb[i], tas[i]);
         compared++;
         if ({out_valid, Cout, Ov, S} !== {1'b1, ec[i], eo[i], es[i]}) begin
            mismatched++;
            $display("FAIL directed[%0d]: got v=%b c=%b o=%b s=%b, want v=1 c=%b o=%b s=%b",
                     i, out_valid, Cout, Ov, S, ec[i], eo[i], es[i]);
         end
      end
   endtask

   task automatic test_a_minus_a;
      logic [W-1:0] a;
      for (int i = 0; i < 4; i++) begin
         a = W'($urandom);
         drive(1'b1, a, a, 1'b1);
         compared++;
         if ({out_valid, Cout, Ov, S} !== {1'b1, 1'b1, 1'b0, {W{1'b0}}}) begin
            mismatched++;
            $display("FAIL a_minus_a(%b): got c=%b o=%b s=%b, want c=1 o=0 s=0",
                     a, Cout, Ov, S);
         end
      end
   endtask

   task automatic test_hold;
      logic [W-1:0] es;
      logic         ec, eo;
      model(5'b00110, 5'b00001, 1'b0, es, ec, eo);
      drive(1'b1, 5'b00110, 5'b00001, 1'b0);
      drive(1'b0, 5'b11111, 5'b11111, 1'b1);
      compared++;
      if ({out_valid, Cout, Ov, S} !== {1'b0, ec, eo, es}) begin
         mismatched++;
         $display("FAIL hold: got v=%b c=%b o=%b s=%b, want v=0 c=%b o=%b s=%b",
                  out_valid, Cout, Ov, S, ec, eo, es);
      end
   endtask

   // Random operands with random in_valid gaps, including long back-to-back runs.
   task automatic test_back_to_back;
      logic [W-1:0] a, b, es, ts;
      logic         as, v, ec, eo, tc, to;
      model(A, BC, AS, es, ec, eo);
      es = S; ec = Cout; eo = Ov;
      for (int i = 0; i < 300; i++) begin
         a  = W'($urandom);
         b  = W'($urandom);
         as = 1'($urandom);
         v  = (i < 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (v) begin
            model(a, b, as, ts, tc, to);
            es = ts; ec = tc; eo = to;
         end
         drive(v, a, b, as);
         compared++;
         if ({out_valid, Cout, Ov, S} !== {v, ec, eo, es}) begin
            mismatched++;
            $display("FAIL random[%0d] %b %s %b: got v=%b c=%b o=%b s=%b, want v=%b c=%b o=%b s=%b",
                     i, a, as ? "-" : "+", b, out_valid, Cout, Ov, S, v, ec, eo, es);
         end
      end
   endtask

   task automatic test_async_reset;
      drive(1'b1, 5'b11011, 5'b10100, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      rst_n    = 1'b0;
      #1;
      compared++;
      if ({out_valid, Cout, Ov, S} !== {1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
         mismatched++;
         $display("FAIL async_reset: got v=%b c=%b o=%b s=%b, want all 0",
                  out_valid, Cout, Ov, S);
      end
      @(posedge clk);
      #1;
      compared++;
      if ({out_valid, S} !== {1'b0, {W{1'b0}}}) begin
         mismatched++;
         $display("FAIL reset_held_edge: got v=%b s=%b, want v=0 s=0", out_valid, S);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 5'b00110, 5'b00001, 1'b1);
      compared++;
      if ({out_valid, Cout, Ov, S} !== {1'b1, 1'b1, 1'b0, 5'b00101}) begin
         mismatched++;
         $display("FAIL post_reset_first: got v=%b c=%b o=%b s=%b, want v=1 c=1 o=0 s=00101",
                  out_valid, Cout, Ov, S);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_directed();
      test_a_minus_a();
      test_hold();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
